// File: rtl/casez_rr_arbiter_pkg.sv
// Shared types and the casez priority decode for the four-way grant arbiter.
// Optional checks elsewhere are enabled by defining CASEZ_RR_ARBITER_ASSERT_EN.
package casez_rr_arbiter_pkg;

  localparam int NREQ_FIXED = 4;

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} arb_state_t;

  typedef logic [1:0] req_id_t;

  // Returns {valid, id}; lowest set bit wins. X bits never match a 1 pattern.
  function automatic logic [2:0] pick(input logic [3:0] v);
    logic [2:0] r;
    r = 3'b000;
    casez (v)
      4'b???1: r = {1'b1, 2'd0};
      4'b??10: r = {1'b1, 2'd1};
      4'b?100: r = {1'b1, 2'd2};
      4'b1000: r = {1'b1, 2'd3};
      default: r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/casez_rr_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface casez_rr_arbiter_if;
  import casez_rr_arbiter_pkg::*;

  logic [NREQ_FIXED-1:0] req;
  logic                  done;
  logic                  mode;
  logic [NREQ_FIXED-1:0] gnt;
  req_id_t               gnt_id;
  logic                  busy;
  logic                  timeout;

  modport master (output req, done, mode, input gnt, gnt_id, busy, timeout);
  modport slave  (input req, done, mode, output gnt, gnt_id, busy, timeout);
endinterface

// File: rtl/casez_rr_arbiter_pick.sv
// Combinational wrapper around the shared casez decode: 4-bit vector in, valid + id out.
module casez_prio_pick
  import casez_rr_arbiter_pkg::*;
(
  input  logic [3:0] v_i,
  output logic       valid_o,
  output req_id_t    id_o
);
  logic [2:0] res;

  assign res     = pick(v_i);
  assign valid_o = res[2];
  assign id_o    = res[1:0];
endmodule

// File: rtl/casez_rr_arbiter.sv
// Four-way arbiter: fixed or round-robin pick in IDLE, bounded hold in GRANT, one-cycle RELEASE gap.
// Define CASEZ_RR_ARBITER_ASSERT_EN to add immediate assertions on the grant outputs and decode.
module casez_rr_arbiter
  import casez_rr_arbiter_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 8
) (
  input logic               clk,
  input logic               rst_n,
  casez_rr_arbiter_if.slave bus
);

  generate
    if (NREQ != NREQ_FIXED) begin : g_bad_nreq
      $error("casez_rr_arbiter: NREQ must be 4");
    end
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
      $error("casez_rr_arbiter: MAX_HOLD must be in 2..255");
    end
  endgenerate

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  arb_state_t state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  req_id_t    gnt_id_q, gnt_id_d;
  req_id_t    last_id_q, last_id_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;

  req_id_t    rr_base;
  logic [7:0] req_dbl;
  logic [3:0] req_rot;
  logic       fix_valid, rr_valid, win_valid, req_known;
  req_id_t    fix_id, rr_off, win_id;

  // Rotating right by rr_base puts the requester after the last owner at bit 0.
  assign rr_base = last_id_q + 2'd1;
  assign req_dbl = {bus.req, bus.req};
  assign req_rot = req_dbl[{1'b0, rr_base} +: 4];

  casez_prio_pick u_pick_fix (.v_i(bus.req), .valid_o(fix_valid), .id_o(fix_id));
  casez_prio_pick u_pick_rr  (.v_i(req_rot), .valid_o(rr_valid),  .id_o(rr_off));

  assign win_valid = bus.mode ? rr_valid : fix_valid;
  assign win_id    = bus.mode ? req_id_t'(rr_off + rr_base) : fix_id;
  assign req_known = (^bus.req !== 1'bx);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    last_id_d  = last_id_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (req_known && win_valid) begin
          gnt_d      = 4'b0001 << win_id;
          gnt_id_d   = win_id;
          busy_d     = 1'b1;
          hold_cnt_d = 8'd0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (hold_cnt_q != HOLD_LAST) hold_cnt_d = hold_cnt_q + 8'd1;
        // Owner-side release outranks expiry, so a coincident done never flags a timeout.
        if (!bus.req[gnt_id_q] || bus.done) begin
          gnt_d     = 4'b0000;
          last_id_d = gnt_id_q;
          state_d   = RELEASE;
        end else if (hold_cnt_q == HOLD_LAST) begin
          gnt_d     = 4'b0000;
          last_id_d = gnt_id_q;
          timeout_d = 1'b1;
          state_d   = RELEASE;
        end
      end
      RELEASE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= 4'b0000;
      gnt_id_q   <= 2'd0;
      last_id_q  <= 2'd3;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      hold_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      last_id_q  <= last_id_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

`ifdef CASEZ_RR_ARBITER_ASSERT_EN
  logic [2:0] ref_pick;

  always_comb begin
    ref_pick = 3'b000;
    if (bus.req[0])      ref_pick = {1'b1, 2'd0};
    else if (bus.req[1]) ref_pick = {1'b1, 2'd1};
    else if (bus.req[2]) ref_pick = {1'b1, 2'd2};
    else if (bus.req[3]) ref_pick = {1'b1, 2'd3};
    if (^bus.req !== 1'bx) begin
      a_gnt_onehot: assert ($onehot0(gnt_q));
      a_gnt_id:     assert (gnt_q == 4'b0000 || gnt_q[gnt_id_q]);
      a_fixed_ref:  assert ({fix_valid, fix_id} == ref_pick);
      a_timeout:    assert (!timeout_q || state_q == RELEASE);
    end
  end
`endif

endmodule

// File: tb/tb_casez_rr_arbiter.sv
// Randomized scoreboard bench: stimulus pushes expected tenures, a negedge monitor pops and compares.
module tb_casez_rr_arbiter;
  localparam int MAX_HOLD = 8;

  typedef struct {
    int id;
    int len;
    int to;
  } exp_t;

  logic clk;
  logic rst_n;
  casez_rr_arbiter_if bus ();

  casez_rr_arbiter #(.NREQ(4), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   model_last = 3;
  int   exp_to = 0;
  int   to_seen = 0;
  bit   mon_en = 1'b0;
  exp_t exp_q[$];

  task automatic check(input string name, input int act, input int req_v);
    checks++;
    if (act != req_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req_v);
    end
  endtask

  // Reference pick: scan requesters starting from the fixed or rotating origin.
  function automatic int model_winner(input logic [3:0] r, input bit m, input int last);
    int start;
    start = m ? (last + 1) % 4 : 0;
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4] == 1'b1) return (start + k) % 4;
    end
    return -1;
  endfunction

  // Called at an IDLE negedge. hold = gnt cycle on which the owner lets go (> MAX_HOLD: never).
  task automatic txn(input logic [3:0] r, input bit m, input int hold, input bit by_drop, input bit keep);
    int   w, lat, k, n;
    exp_t e;
    bus.mode = m;
    bus.req  = r;
    bus.done = 1'b0;
    w = $isunknown(r) ? -1 : model_winner(r, m, model_last);
    if (w < 0) begin
      repeat (3) @(negedge clk);
      check("no_grant", int'(bus.gnt), 0);
      bus.req = 4'b0000;
      return;
    end
    e.id  = w;
    e.len = (hold > MAX_HOLD) ? MAX_HOLD : hold;
    e.to  = (hold > MAX_HOLD) ? 1 : 0;
    exp_q.push_back(e);
    exp_to += e.to;
    model_last = w;
    lat = 0;
    while (bus.gnt == 4'b0000 && lat < 4) begin
      @(negedge clk);
      lat++;
    end
    check("grant_latency", lat, 1);
    k = 1;
    while (k <= hold && bus.gnt != 4'b0000) begin
      if (k == hold) begin
        if (by_drop) bus.req[w] = 1'b0;
        else         bus.done   = 1'b1;
      end
      @(negedge clk);
      k++;
    end
    n = 0;
    while (bus.gnt != 4'b0000 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) check("release_bound", 0, 1);
    bus.done = 1'b0;
    if (!keep) bus.req = 4'b0000;
    n = 0;
    while (bus.busy && n < 5) begin
      @(negedge clk);
      n++;
    end
    if (n == 5) check("idle_bound", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    mon_en   = 1'b0;
    rst_n    = 1'b0;
    bus.req  = 4'b0000;
    bus.done = 1'b0;
    repeat (2) @(negedge clk);
    rst_n      = 1'b1;
    model_last = 3;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  initial begin : monitor
    bit   in_ten;
    int   cur_id, cur_len;
    exp_t e;
    in_ten = 1'b0;
    cur_id = 0;
    cur_len = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        in_ten = 1'b0;
        continue;
      end
      if (bus.timeout) to_seen++;
      if (bus.gnt != 4'b0000) begin
        check("gnt_onehot_id", int'(bus.gnt), int'(4'b0001 << bus.gnt_id));
        if (!in_ten) begin
          in_ten  = 1'b1;
          cur_id  = int'(bus.gnt_id);
          cur_len = 0;
        end
        cur_len++;
      end else if (in_ten) begin
        in_ten = 1'b0;
        $display("txn id=%0d len=%0d timeout=%0d", cur_id, cur_len, bus.timeout);
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("owner_id", cur_id, e.id);
          check("tenure", cur_len, e.len);
          check("timeout", int'(bus.timeout), e.to);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [3:0] r;
    rst_n    = 1'b0;
    bus.req  = 4'b0000;
    bus.done = 1'b0;
    bus.mode = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_gnt", int'(bus.gnt), 0);
    check("rst_gnt_id", int'(bus.gnt_id), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_timeout", int'(bus.timeout), 0);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    txn(4'b0110, 1'b0, 3, 1'b1, 1'b1);
    txn(4'b0100, 1'b0, 2, 1'b0, 1'b0);

    // Reset in the middle of a tenure owned by requester 2.
    mon_en   = 1'b0;
    bus.mode = 1'b0;
    bus.req  = 4'b0100;
    @(negedge clk);
    check("pre_rst_gnt", int'(bus.gnt), 4);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_gnt", int'(bus.gnt), 0);
    check("async_rst_busy", int'(bus.busy), 0);
    bus.req = 4'b0000;
    @(negedge clk);
    rst_n      = 1'b1;
    model_last = 3;
    @(negedge clk);
    mon_en = 1'b1;
    txn(4'b0101, 1'b1, 2, 1'b0, 1'b0);

    do_reset();
    for (int i = 0; i < 5; i++) txn(4'b1111, 1'b1, 2, 1'b0, (i < 4));

    txn(4'b1000, 1'b0, MAX_HOLD + 2, 1'b0, 1'b1);
    txn(4'b1000, 1'b0, 2, 1'b0, 1'b0);
    txn(4'b0001, 1'b0, MAX_HOLD, 1'b0, 1'b0);
    txn(4'b0x00, 1'b0, 2, 1'b0, 1'b0);
    txn(4'b0100, 1'b0, 2, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      r = 4'($urandom_range(1, 15));
      txn(r, 1'($urandom_range(0, 1)), int'($urandom_range(1, MAX_HOLD + 2)),
          1'($urandom_range(0, 1)), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("pending_expected", exp_q.size(), 0);
    check("timeout_pulses", to_seen, exp_to);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
